pp_pipeline_accel_fpext_lanes: RTL and testbench

- Multi-lane, parametrised single-to-double precision converter (fp32 -> fp64) for the pp_pipeline_accel datapath.
- Implemented in plain RTL, with no vendor IP core and no DSP.
- Adds per-lane valid tracking, a configurable pipeline depth, and a clock-enable stall that freezes the whole pipe.
- Full IEEE-754 handling, including normalisation of fp32 subnormals.

---
 rtl/pp_pipeline_accel_fpext_lanes.sv | 182 ++++++++++++++++++
 tb/tb_pp_pipeline_accel_fpext_lanes.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_pipeline_accel_fpext_lanes.sv
// pp_pipeline_accel_fpext_lanes
// Multi-lane fp32 -> fp64 converter with per-lane valid tracking, a
// configurable pipeline depth (NUM_STAGE = 2..4) and a ce-driven stall.
// Stage 1 registers the operands; class/lz decode follows; optional plain
// register slices carry the decode word; the final stage assembles fp64.
// Optional sticky status flags are enabled with the macro PP_FPEXT_FLAGS_EN.
module pp_pipeline_accel_fpext_lanes #(
  parameter int ID         = 1,
  parameter int NUM_LANES  = 2,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 32,
  parameter int dout_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic [NUM_LANES-1:0]              vld_in,
  input  logic [NUM_LANES*din0_WIDTH-1:0]   din0,
`ifdef PP_FPEXT_FLAGS_EN
  input  logic                              flag_clr,
  output logic [NUM_LANES-1:0]              flag_invalid,
  output logic [NUM_LANES-1:0]              flag_denorm,
`endif
  output logic [NUM_LANES-1:0]              vld_out,
  output logic [NUM_LANES*dout_WIDTH-1:0]   dout
);

  // Decode word: [39] valid, [38] sign, [37:36] class, [35:28] exp,
  // [27:5] mantissa, [4:0] leading-zero count of the mantissa.
  localparam int DW = 40;
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_SUB  = 2'd1;
  localparam logic [1:0] CLS_NORM = 2'd2;
  localparam logic [1:0] CLS_SPEC = 2'd3;

  // Widths are fixed; ID is only an instance tag.
  if (din0_WIDTH != 32 || dout_WIDTH != 64 || NUM_STAGE < 2 || NUM_STAGE > 4 ||
      NUM_LANES < 1 || NUM_LANES > 8 || ID < 0) begin : g_param_check
    $error("pp_pipeline_accel_fpext_lanes: unsupported parameter set");
  end

  function automatic logic [4:0] clz23(input logic [22:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] decode(input logic v, input logic [31:0] x);
    logic [1:0] cls;
    if (x[30:23] == 8'd0)       cls = (x[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    else if (x[30:23] == 8'hFF) cls = CLS_SPEC;
    else                        cls = CLS_NORM;
    return {v, x[31], cls, x[30:23], x[22:0], clz23(x[22:0])};
  endfunction

  function automatic logic [63:0] assemble(input logic [DW-1:0] d);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  lz;
    logic [22:0] fr;
    logic [63:0] r;
    s  = d[38];
    e  = d[35:28];
    m  = d[27:5];
    lz = d[4:0];
    fr = m << (lz + 5'd1);
    case (d[37:36])
      CLS_ZERO: r = {s, 63'd0};
      // Subnormal: shift the leading one out (it becomes the hidden bit).
      CLS_SUB:  r = {s, 11'd896 - {6'd0, lz}, fr, 29'd0};
      CLS_NORM: r = {s, {3'd0, e} + 11'd896, m, 29'd0};
      default:  r = (m == 23'd0) ? {s, 11'h7FF, 52'd0}
                                 : {s, 11'h7FF, 1'b1, m[21:0], 29'd0};
    endcase
    return r;
  endfunction

  logic [NUM_LANES*32-1:0] s1_data;
  logic [NUM_LANES-1:0]    s1_vld;
  logic [NUM_LANES*DW-1:0] dec_c;
  logic [NUM_LANES*DW-1:0] asm_in;
  logic [NUM_LANES*64-1:0] asm_c;
  logic [NUM_LANES-1:0]    vld_c;

  // Stage 1: operand and valid capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_data <= '0;
      s1_vld  <= '0;
    end else if (ce) begin
      s1_data <= din0;
      s1_vld  <= vld_in;
    end
  end

  // Class decode and leading-zero count per lane.
  always_comb begin
    dec_c = '0;
    for (int k = 0; k < NUM_LANES; k++)
      dec_c[k*DW +: DW] = decode(s1_vld[k], s1_data[k*32 +: 32]);
  end

  if (NUM_STAGE == 2) begin : g_merged
    assign asm_in = dec_c;
  end else begin : g_slices
    logic [NUM_LANES*DW-1:0] slc [NUM_STAGE-2];

    // Decode register followed by plain slices ahead of the output stage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < NUM_STAGE - 2; i++) slc[i] <= '0;
      end else if (ce) begin
        slc[0] <= dec_c;
        for (int i = 1; i < NUM_STAGE - 2; i++) slc[i] <= slc[i-1];
      end
    end

    assign asm_in = slc[NUM_STAGE-3];
  end

  // fp64 assembly per lane.
  always_comb begin
    asm_c = '0;
    vld_c = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      asm_c[k*64 +: 64] = assemble(asm_in[k*DW +: DW]);
      vld_c[k]          = asm_in[k*DW + 39];
    end
  end

  // Output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout    <= '0;
      vld_out <= '0;
    end else if (ce) begin
      dout    <= asm_c;
      vld_out <= vld_c;
    end
  end

`ifdef PP_FPEXT_FLAGS_EN
  logic [NUM_LANES-1:0] inv_c;
  logic [NUM_LANES-1:0] den_c;

  // Flag events for the word entering the output stage: signalling NaN
  // (quiet bit clear, payload non-zero) and subnormal operand.
  always_comb begin
    inv_c = '0;
    den_c = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      inv_c[k] = vld_c[k] && (asm_in[k*DW + 36 +: 2] == CLS_SPEC) &&
                 (asm_in[k*DW + 5 +: 23] != 23'd0) && !asm_in[k*DW + 27];
      den_c[k] = vld_c[k] && (asm_in[k*DW + 36 +: 2] == CLS_SUB);
    end
  end

  // Sticky flags; a clear wins over a same-edge set and ignores ce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_invalid <= '0;
      flag_denorm  <= '0;
    end else if (flag_clr) begin
      flag_invalid <= '0;
      flag_denorm  <= '0;
    end else if (ce) begin
      flag_invalid <= flag_invalid | inv_c;
      flag_denorm  <= flag_denorm | den_c;
    end
  end
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fpext_lanes.sv
// Directed bench for pp_pipeline_accel_fpext_lanes: a 2-stage and a 4-stage
// instance share stimulus; expected fp64 words are hand-computed constants.
module tb_pp_pipeline_accel_fpext_lanes;

  logic         clk;
  logic         reset;
  logic         ce;
  logic [1:0]   vld_in;
  logic [63:0]  din0;
  logic [1:0]   vld_out;
  logic [127:0] dout;
  logic [1:0]   vld_out4;
  logic [127:0] dout4;
`ifdef PP_FPEXT_FLAGS_EN
  logic         flag_clr;
  logic [1:0]   flag_invalid, flag_denorm;
  logic [1:0]   flag_invalid4, flag_denorm4;
`endif

  int vectors;
  int miscompares;

  pp_pipeline_accel_fpext_lanes #(.ID(1), .NUM_LANES(2), .NUM_STAGE(2)) dut (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0),
`ifdef PP_FPEXT_FLAGS_EN
    .flag_clr(flag_clr), .flag_invalid(flag_invalid), .flag_denorm(flag_denorm),
`endif
    .vld_out(vld_out), .dout(dout));

  pp_pipeline_accel_fpext_lanes #(.ID(2), .NUM_LANES(2), .NUM_STAGE(4)) dut4 (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0),
`ifdef PP_FPEXT_FLAGS_EN
    .flag_clr(flag_clr), .flag_invalid(flag_invalid4), .flag_denorm(flag_denorm4),
`endif
    .vld_out(vld_out4), .dout(dout4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vld(input string nm, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s vld_out got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dout got %h expected %h", nm, got, exp);
    end
  endtask

  // Capture one operand pair, check 2-edge latency and that the slot drains.
  task automatic run_pair(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [1:0] v, input logic [63:0] e0, input logic [63:0] e1);
    din0   = {a1, a0};
    vld_in = v;
    ce     = 1'b1;
    step();
    vld_in = 2'b00;
    chk_vld({nm, "_edge1"}, vld_out, 2'b00);
    step();
    chk_vld({nm, "_edge2"}, vld_out, v);
    if (v[0]) chk_word({nm, "_lane0"}, dout[63:0], e0);
    if (v[1]) chk_word({nm, "_lane1"}, dout[127:64], e1);
    step();
    chk_vld({nm, "_drain"}, vld_out, 2'b00);
  endtask

  task automatic test_reset();
    chk_vld("reset_vld", vld_out, 2'b00);
    chk_word("reset_dout_lo", dout[63:0], 64'd0);
    chk_word("reset_dout_hi", dout[127:64], 64'd0);
    chk_vld("reset_vld4", vld_out4, 2'b00);
    #4 reset = 1'b1;
    step();
    chk_vld("reset_release_vld", vld_out, 2'b00);
  endtask

  task automatic test_normal();
    run_pair("norm", 32'h3F800000, 32'hFF800000, 2'b11,
             64'h3FF0000000000000, 64'hFFF0000000000000);
  endtask

  task automatic test_subnormal();
    run_pair("subn", 32'h00000001, 32'h007FFFFF, 2'b11,
             64'h36A0000000000000, 64'h380FFFFFC0000000);
  endtask

  task automatic test_nan_zero();
    run_pair("nanz", 32'h7F800001, 32'h80000000, 2'b11,
             64'h7FF8000020000000, 64'h8000000000000000);
`ifdef PP_FPEXT_FLAGS_EN
    vectors++;
    if (flag_invalid !== 2'b01) begin
      miscompares++;
      $display("FAIL flag_invalid got %b expected %b", flag_invalid, 2'b01);
    end
    vectors++;
    if (flag_denorm !== 2'b11) begin
      miscompares++;
      $display("FAIL flag_denorm got %b expected %b", flag_denorm, 2'b11);
    end
    repeat (3) step();
    vectors++;
    if (flag_invalid !== 2'b01) begin
      miscompares++;
      $display("FAIL flag_sticky got %b expected %b", flag_invalid, 2'b01);
    end
    ce       = 1'b0;
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    ce       = 1'b1;
    vectors++;
    if ({flag_invalid, flag_denorm} !== 4'b0000) begin
      miscompares++;
      $display("FAIL flag_clr got %b expected %b", {flag_invalid, flag_denorm}, 4'b0000);
    end
`endif
  endtask

  task automatic test_valid_gating();
    run_pair("gate", 32'h40490FDB, 32'h40490FDB, 2'b01,
             64'h400921FB60000000, 64'h400921FB60000000);
  endtask

  task automatic test_stall();
    din0   = {32'hC0000000, 32'h3F800000};
    vld_in = 2'b11;
    ce     = 1'b1;
    step();
    vld_in = 2'b00;
    ce     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_vld("stall_empty", vld_out, 2'b00);
    end
    ce = 1'b1;
    step();
    chk_vld("stall_result", vld_out, 2'b11);
    chk_word("stall_lane0", dout[63:0], 64'h3FF0000000000000);
    chk_word("stall_lane1", dout[127:64], 64'hC000000000000000);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_vld("stall_hold_vld", vld_out, 2'b11);
      chk_word("stall_hold_dout", dout[63:0], 64'h3FF0000000000000);
    end
    ce = 1'b1;
    step();
    chk_vld("stall_no_dup", vld_out, 2'b00);
  endtask

  task automatic test_async_reset();
    din0   = {32'h3F800000, 32'h3F800000};
    vld_in = 2'b11;
    ce     = 1'b1;
    repeat (4) step();
    chk_vld("ar_full_vld4", vld_out4, 2'b11);
    chk_word("ar_full_lane0", dout4[63:0], 64'h3FF0000000000000);
    #1 reset = 1'b0;
    #1;
    chk_vld("ar_clear_vld4", vld_out4, 2'b00);
    chk_word("ar_clear_lo4", dout4[63:0], 64'd0);
    chk_word("ar_clear_hi4", dout4[127:64], 64'd0);
    chk_vld("ar_clear_vld2", vld_out, 2'b00);
    #1;
    din0   = {32'h40490FDB, 32'h00000001};
    vld_in = 2'b11;
    reset  = 1'b1;
    step();
    vld_in = 2'b00;
    for (int i = 1; i < 4; i++) begin
      chk_vld("ar_latency_empty", vld_out4, 2'b00);
      step();
    end
    chk_vld("ar_result_vld4", vld_out4, 2'b11);
    chk_word("ar_result_lane0", dout4[63:0], 64'h36A0000000000000);
    chk_word("ar_result_lane1", dout4[127:64], 64'h400921FB60000000);
    step();
    chk_vld("ar_drain_vld4", vld_out4, 2'b00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    ce          = 1'b0;
    vld_in      = 2'b00;
    din0        = 64'd0;
`ifdef PP_FPEXT_FLAGS_EN
    flag_clr    = 1'b0;
`endif
    #2;
    test_reset();
    test_normal();
    test_subnormal();
    test_nan_zero();
    test_valid_gating();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
